vram_port_b_arbiter: RTL and testbench
======================================

VRAM_PORT_B_ARBITER -- requirements
Module: vram_port_b_arbiter

Interface
REQ-001 Parameters SHALL be: ADDRESS_WIDTH, default 16, VRAM address width; DATA_WIDTH, default 16, VRAM word width; STARVE_LIMIT, default 4, the maximum number of consecutive lost arbitrations for host.
REQ-002 The block SHALL use one clock; reset SHALL be synchronous and active-low.
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clock, in, 1, rising-edge clock.
- reset_n, in, 1, synchronous active-low reset.
- scan_req, in, 1, display scanout read request.
- scan_address, in, ADDRESS_WIDTH, scanout read address.
- scan_grant, out, 1, scanout access issued this cycle.
- scan_data_valid, out, 1, scan_data is valid.
- scan_data, out, DATA_WIDTH, scanout read data.
- host_req, in, 1, host/debug access request.
- host_write, in, 1, host access type: 1 = write, 0 = read.
- host_address, in, ADDRESS_WIDTH, host address.
- host_data_in, in, DATA_WIDTH, host write data.
- host_grant, out, 1, host access issued this cycle.
- host_data_valid, out, 1, host_data is valid.
- host_data, out, DATA_WIDTH, host read data.
- ram_enable_b, out, 1, VRAM port B enable.
- ram_rw_b, out, 1, VRAM port B direction: 1 = write.
- ram_address_b, out, ADDRESS_WIDTH, VRAM port B address.
- ram_data_in_b, out, DATA_WIDTH, VRAM port B write data.
- ram_data_out_b, in, DATA_WIDTH, VRAM port B read data (synchronous RAM, 1-cycle latency).

Function
REQ-004 The FSM SHALL have the states IDLE, SCAN_ACCESS and HOST_ACCESS, re-evaluated on every rising edge.
REQ-005 At each edge, the request winner SHALL be captured as follows: address, write data and rw into registers; the FSM moves to the winner's ACCESS state; if there is no request, the FSM moves to IDLE.
REQ-006 In SCAN_ACCESS and HOST_ACCESS, ram_enable_b SHALL be 1 and the ram_* outputs SHALL be driven from the captured registers; the matching grant SHALL be 1 for exactly that cycle.
REQ-007 In IDLE: ram_enable_b=0, ram_rw_b=0, both grants=0; address and data outputs SHALL hold their last values.
REQ-008 Default priority SHALL be scan over host.
REQ-009 Starvation counter: it SHALL increment at each edge where host_req=1 and scan wins, and clear on host grant or when host_req=0.
REQ-010 When the starvation counter equals STARVE_LIMIT, host SHALL win the next arbitration even when scan_req=1.
REQ-011 The counter SHALL saturate at STARVE_LIMIT and never wrap.
REQ-012 Scan accesses SHALL always be reads (ram_rw_b=0).
REQ-013 For any granted read, <x>_data_valid SHALL be 1 for exactly the cycle after the grant, with <x>_data = ram_data_out_b.
REQ-014 Host writes SHALL NOT produce host_data_valid.
REQ-015 Throughput SHALL be one access per cycle. A req still high during its grant cycle is a new request, so back-to-back grants with no bubble are allowed.
REQ-016 A req deasserted before grant SHALL cancel with no RAM access. Requesters SHALL hold address, data and write stable while req=1 and not granted.
REQ-017 Simultaneous requests SHALL resolve per REQ-008 and REQ-010. Exactly one grant SHALL be active per cycle, never both.
REQ-018 scan_data and host_data SHALL hold their last valid value when their data_valid is 0.

Reset
REQ-019 While reset_n=0 at an edge, the next state SHALL be: state=IDLE, grants=0, data_valids=0, ram_enable_b=0, ram_rw_b=0, starvation counter=0, captured address and data=0, scan_data=0, host_data=0.
REQ-020 Reset during an access or pending read SHALL suppress the pending data_valid; no valid SHALL be emitted after reset deasserts.
REQ-021 The first arbitration SHALL occur at the first edge with reset_n=1.

Structure
REQ-022 Shared package vram_arb_pkg SHALL hold the state enum (IDLE, SCAN_ACCESS, HOST_ACCESS) and the RW_WRITE/RW_READ encoding constants.
REQ-023 The starvation counter SHALL be a sub-module named starvation_counter, with parameter LIMIT, inputs increment and clear, and output at_limit.

Verification
REQ-024 Reset then idle: reset_n=0 for 2 cycles, then no requests. Required: all outputs 0, ram_enable_b=0 throughout.
REQ-025 Scan read: VRAM[0x0010]=0xBEEF; scan_req=1, scan_address=0x0010 for 1 edge. Required: scan_grant pulse, ram_address_b=0x0010, ram_rw_b=0; next cycle scan_data_valid=1 with scan_data=0xBEEF.
REQ-026 Host write then read: host_write=1, address 0x0020, data 0x1234, then host_write=0, same address. Required: two consecutive host_grant cycles, then host_data_valid=1 with host_data=0x1234.
REQ-027 Starvation: scan_req and host_req held at 1 continuously. Required: grant pattern 4 scan, 1 host, repeating; never both grants high.
REQ-028 Cancel: host_req=1 for 1 cycle while scan wins, then host_req=0. Required: no host_grant, no write to VRAM, counter back to 0.
REQ-029 Reset mid-read: reset_n=0 during a scan_grant cycle. Required: scan_data_valid stays 0 and state=IDLE after reset.

Source files
------------

// File: rtl/vram_arb_pkg.sv
// Shared definitions for the VRAM port B arbiter: FSM state encoding and
// the port B read/write direction constants.
package vram_arb_pkg;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SCAN_ACCESS = 2'd1,
    HOST_ACCESS = 2'd2
  } state_t;

  localparam logic RW_WRITE = 1'b1;
  localparam logic RW_READ  = 1'b0;

endpackage

// File: rtl/starvation_counter.sv
// Counts consecutive arbitrations the host lost to scanout; saturates at LIMIT
// so at_limit stays asserted until the host is finally served or withdraws.
module starvation_counter #(
  parameter int LIMIT = 4
) (
  input  logic clock,
  input  logic reset_n,
  input  logic increment,
  input  logic clear,
  output logic at_limit
);

  localparam int CW = (LIMIT < 1) ? 1 : $clog2(LIMIT + 1);
  localparam logic [CW-1:0] LIMIT_VAL = CW'(LIMIT);

  logic [CW-1:0] count_reg;

  always_ff @(posedge clock) begin
    if (!reset_n || clear) begin
      count_reg <= '0;
    end else if (increment && (count_reg != LIMIT_VAL)) begin
      count_reg <= count_reg + 1'b1;
    end
  end

  assign at_limit = (count_reg == LIMIT_VAL);

endmodule

// File: rtl/vram_port_b_arbiter.sv
// Arbitrates VRAM port B between display scanout (priority) and a host/debug
// port, with a starvation guard that forces a host win after STARVE_LIMIT losses.
module vram_port_b_arbiter
  import vram_arb_pkg::*;
#(
  parameter int ADDRESS_WIDTH = 16,
  parameter int DATA_WIDTH    = 16,
  parameter int STARVE_LIMIT  = 4
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     scan_req,
  input  logic [ADDRESS_WIDTH-1:0] scan_address,
  output logic                     scan_grant,
  output logic                     scan_data_valid,
  output logic [DATA_WIDTH-1:0]    scan_data,
  input  logic                     host_req,
  input  logic                     host_write,
  input  logic [ADDRESS_WIDTH-1:0] host_address,
  input  logic [DATA_WIDTH-1:0]    host_data_in,
  output logic                     host_grant,
  output logic                     host_data_valid,
  output logic [DATA_WIDTH-1:0]    host_data,
  output logic                     ram_enable_b,
  output logic                     ram_rw_b,
  output logic [ADDRESS_WIDTH-1:0] ram_address_b,
  output logic [DATA_WIDTH-1:0]    ram_data_in_b,
  input  logic [DATA_WIDTH-1:0]    ram_data_out_b
);

  state_t                   state_reg, state_next;
  logic [ADDRESS_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0]    wdata_reg;
  logic                     rw_reg;
  logic                     scan_valid_reg, host_valid_reg;
  logic [DATA_WIDTH-1:0]    scan_hold_reg, host_hold_reg;
  logic                     at_limit;
  logic                     host_wins, scan_wins;

  starvation_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clock     (clock),
    .reset_n   (reset_n),
    .increment (scan_wins && host_req),
    .clear     (host_wins || !host_req),
    .at_limit  (at_limit)
  );

  always_comb begin
    host_wins  = host_req && (!scan_req || at_limit);
    scan_wins  = scan_req && !host_wins;
    state_next = IDLE;
    if (host_wins) begin
      state_next = HOST_ACCESS;
    end else if (scan_wins) begin
      state_next = SCAN_ACCESS;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_reg      <= IDLE;
      addr_reg       <= '0;
      wdata_reg      <= '0;
      rw_reg         <= RW_READ;
      scan_valid_reg <= 1'b0;
      host_valid_reg <= 1'b0;
      scan_hold_reg  <= '0;
      host_hold_reg  <= '0;
    end else begin
      state_reg <= state_next;
      // Capture registers only move on a win so they hold through IDLE.
      if (host_wins) begin
        addr_reg  <= host_address;
        wdata_reg <= host_data_in;
        rw_reg    <= host_write ? RW_WRITE : RW_READ;
      end else if (scan_wins) begin
        addr_reg <= scan_address;
        rw_reg   <= RW_READ;
      end
      scan_valid_reg <= (state_reg == SCAN_ACCESS);
      host_valid_reg <= (state_reg == HOST_ACCESS) && (rw_reg == RW_READ);
      if (scan_valid_reg) scan_hold_reg <= ram_data_out_b;
      if (host_valid_reg) host_hold_reg <= ram_data_out_b;
    end
  end

  assign scan_grant    = (state_reg == SCAN_ACCESS);
  assign host_grant    = (state_reg == HOST_ACCESS);
  assign ram_enable_b  = (state_reg != IDLE);
  assign ram_rw_b      = host_grant ? rw_reg : RW_READ;
  assign ram_address_b = addr_reg;
  assign ram_data_in_b = wdata_reg;

  // RAM output is only live in the valid cycle; afterwards the held copy is shown.
  assign scan_data_valid = scan_valid_reg;
  assign host_data_valid = host_valid_reg;
  assign scan_data       = scan_valid_reg ? ram_data_out_b : scan_hold_reg;
  assign host_data       = host_valid_reg ? ram_data_out_b : host_hold_reg;

endmodule

// File: tb/tb_vram_port_b_arbiter.sv
// Directed bench for vram_port_b_arbiter: table of per-cycle vectors plus
// hand-written starvation, cancel and reset-during-read sequences.
module tb_vram_port_b_arbiter;

  logic        clock = 1'b0;
  logic        reset_n;
  logic        scan_req;
  logic [15:0] scan_address;
  logic        scan_grant, scan_data_valid;
  logic [15:0] scan_data;
  logic        host_req, host_write;
  logic [15:0] host_address, host_data_in;
  logic        host_grant, host_data_valid;
  logic [15:0] host_data;
  logic        ram_enable_b, ram_rw_b;
  logic [15:0] ram_address_b, ram_data_in_b;
  logic [15:0] ram_data_out_b;

  logic [15:0] mem [0:255];
  int          checks = 0;
  int          errors = 0;

  always #5 clock = ~clock;

  vram_port_b_arbiter #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (16),
    .STARVE_LIMIT  (4)
  ) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .scan_req        (scan_req),
    .scan_address    (scan_address),
    .scan_grant      (scan_grant),
    .scan_data_valid (scan_data_valid),
    .scan_data       (scan_data),
    .host_req        (host_req),
    .host_write      (host_write),
    .host_address    (host_address),
    .host_data_in    (host_data_in),
    .host_grant      (host_grant),
    .host_data_valid (host_data_valid),
    .host_data       (host_data),
    .ram_enable_b    (ram_enable_b),
    .ram_rw_b        (ram_rw_b),
    .ram_address_b   (ram_address_b),
    .ram_data_in_b   (ram_data_in_b),
    .ram_data_out_b  (ram_data_out_b)
  );

  // Synchronous single-port RAM model, one-cycle read latency; preloaded in reset.
  always @(posedge clock) begin
    if (!reset_n) begin
      mem[8'h10] <= 16'hBEEF;
      mem[8'h11] <= 16'hCAFE;
      mem[8'h20] <= 16'h0000;
      mem[8'h30] <= 16'h5A5A;
    end else if (ram_enable_b) begin
      if (ram_rw_b) mem[ram_address_b[7:0]] <= ram_data_in_b;
      else          ram_data_out_b <= mem[ram_address_b[7:0]];
    end
  end

  typedef struct {
    logic        sreq;
    logic [15:0] saddr;
    logic        hreq;
    logic        hwr;
    logic [15:0] haddr;
    logic [15:0] hdin;
    logic        sg;
    logic        hg;
    logic        en;
    logic        rw;
    logic [15:0] addr;
    logic        sv;
    logic        hv;
    logic [15:0] sd;
    logic [15:0] hd;
  } vec_t;

  vec_t vecs [0:10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input logic sr, input logic [15:0] sa, input logic hr,
                       input logic hw, input logic [15:0] ha, input logic [15:0] hdi);
    scan_req     = sr;
    scan_address = sa;
    host_req     = hr;
    host_write   = hw;
    host_address = ha;
    host_data_in = hdi;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " scan_grant"},      32'(scan_grant),      32'd0);
    check({tag, " host_grant"},      32'(host_grant),      32'd0);
    check({tag, " ram_enable_b"},    32'(ram_enable_b),    32'd0);
    check({tag, " ram_rw_b"},        32'(ram_rw_b),        32'd0);
    check({tag, " ram_address_b"},   32'(ram_address_b),   32'd0);
    check({tag, " ram_data_in_b"},   32'(ram_data_in_b),   32'd0);
    check({tag, " scan_data_valid"}, 32'(scan_data_valid), 32'd0);
    check({tag, " host_data_valid"}, 32'(host_data_valid), 32'd0);
    check({tag, " scan_data"},       32'(scan_data),       32'd0);
    check({tag, " host_data"},       32'(host_data),       32'd0);
  endtask

  initial begin
    vecs[0]  = '{0, 'h00, 0, 0, 'h00, 'h0000, 0, 0, 0, 0, 'h00, 0, 0, 'h0000, 'h0000};
    vecs[1]  = '{1, 'h10, 0, 0, 'h00, 'h0000, 1, 0, 1, 0, 'h10, 0, 0, 'h0000, 'h0000};
    vecs[2]  = '{0, 'h00, 0, 0, 'h00, 'h0000, 0, 0, 0, 0, 'h10, 1, 0, 'hBEEF, 'h0000};
    vecs[3]  = '{0, 'h00, 1, 1, 'h20, 'h1234, 0, 1, 1, 1, 'h20, 0, 0, 'hBEEF, 'h0000};
    vecs[4]  = '{0, 'h00, 1, 0, 'h20, 'h1234, 0, 1, 1, 0, 'h20, 0, 0, 'hBEEF, 'h0000};
    vecs[5]  = '{0, 'h00, 0, 0, 'h00, 'h0000, 0, 0, 0, 0, 'h20, 0, 1, 'hBEEF, 'h1234};
    vecs[6]  = '{1, 'h11, 1, 0, 'h20, 'h0000, 1, 0, 1, 0, 'h11, 0, 0, 'hBEEF, 'h1234};
    vecs[7]  = '{0, 'h00, 0, 0, 'h00, 'h0000, 0, 0, 0, 0, 'h11, 1, 0, 'hCAFE, 'h1234};
    vecs[8]  = '{0, 'h00, 1, 0, 'h10, 'h0000, 0, 1, 1, 0, 'h10, 0, 0, 'hCAFE, 'h1234};
    vecs[9]  = '{1, 'h20, 0, 0, 'h00, 'h0000, 1, 0, 1, 0, 'h20, 0, 1, 'hCAFE, 'hBEEF};
    vecs[10] = '{0, 'h00, 0, 0, 'h00, 'h0000, 0, 0, 0, 0, 'h20, 1, 0, 'h1234, 'hBEEF};

    // Reset then idle
    reset_n = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    step();
    check_all_zero("reset1");
    step();
    check_all_zero("reset2");
    reset_n = 1'b1;

    // Table-driven vectors: inputs sampled at the edge, outputs checked just after
    for (int i = 0; i <= 10; i++) begin
      string t;
      t = $sformatf("vec%0d", i);
      drive(vecs[i].sreq, vecs[i].saddr, vecs[i].hreq, vecs[i].hwr, vecs[i].haddr, vecs[i].hdin);
      step();
      $display("%s sg=%0d hg=%0d en=%0d rw=%0d addr=%h sv=%0d sd=%h hv=%0d hd=%h",
               t, scan_grant, host_grant, ram_enable_b, ram_rw_b, ram_address_b,
               scan_data_valid, scan_data, host_data_valid, host_data);
      check({t, " scan_grant"},      32'(scan_grant),      32'(vecs[i].sg));
      check({t, " host_grant"},      32'(host_grant),      32'(vecs[i].hg));
      check({t, " ram_enable_b"},    32'(ram_enable_b),    32'(vecs[i].en));
      check({t, " ram_rw_b"},        32'(ram_rw_b),        32'(vecs[i].rw));
      check({t, " ram_address_b"},   32'(ram_address_b),   32'(vecs[i].addr));
      check({t, " scan_data_valid"}, 32'(scan_data_valid), 32'(vecs[i].sv));
      check({t, " host_data_valid"}, 32'(host_data_valid), 32'(vecs[i].hv));
      check({t, " scan_data"},       32'(scan_data),       32'(vecs[i].sd));
      check({t, " host_data"},       32'(host_data),       32'(vecs[i].hd));
      if (vecs[i].en && vecs[i].rw)
        check({t, " ram_data_in_b"}, 32'(ram_data_in_b), 32'(vecs[i].hdin));
    end

    // Starvation: both requests held, expect 4 scan then 1 host repeating
    drive(1, 16'h11, 1, 0, 16'h10, 16'h0);
    for (int k = 1; k <= 15; k++) begin
      logic exp_h;
      exp_h = ((k % 5) == 0);
      step();
      $display("starve%0d sg=%0d hg=%0d", k, scan_grant, host_grant);
      check($sformatf("starve%0d host_grant", k), 32'(host_grant), 32'(exp_h));
      check($sformatf("starve%0d scan_grant", k), 32'(scan_grant), 32'(!exp_h));
      check($sformatf("starve%0d both", k), 32'(scan_grant & host_grant), 32'd0);
    end

    // Cancel: host write loses once then withdraws; no write, counter cleared
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    step();
    drive(1, 16'h11, 1, 1, 16'h30, 16'hDEAD);
    step();
    $display("cancel1 sg=%0d hg=%0d", scan_grant, host_grant);
    check("cancel1 host_grant", 32'(host_grant), 32'd0);
    check("cancel1 scan_grant", 32'(scan_grant), 32'd1);
    drive(1, 16'h11, 0, 0, 16'h0, 16'h0);
    step();
    $display("cancel2 sg=%0d hg=%0d", scan_grant, host_grant);
    check("cancel2 host_grant", 32'(host_grant), 32'd0);
    drive(1, 16'h11, 1, 0, 16'h30, 16'h0);
    for (int k = 1; k <= 5; k++) begin
      step();
      $display("post_cancel%0d sg=%0d hg=%0d", k, scan_grant, host_grant);
      check($sformatf("post_cancel%0d host_grant", k), 32'(host_grant), 32'(k == 5));
    end
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    step();
    $display("cancel_read hv=%0d hd=%h", host_data_valid, host_data);
    check("cancel_read host_data_valid", 32'(host_data_valid), 32'd1);
    check("cancel_read host_data", 32'(host_data), 32'h5A5A);
    check("cancel mem30", 32'(mem[8'h30]), 32'h5A5A);

    // Reset during a scan grant cycle must swallow the pending valid
    drive(1, 16'h10, 0, 0, 16'h0, 16'h0);
    step();
    $display("rst_mid grant sg=%0d", scan_grant);
    check("rst_mid scan_grant", 32'(scan_grant), 32'd1);
    reset_n = 1'b0;
    drive(0, 16'h0, 0, 0, 16'h0, 16'h0);
    step();
    $display("rst_mid reset sv=%0d en=%0d", scan_data_valid, ram_enable_b);
    check_all_zero("rst_mid_reset");
    reset_n = 1'b1;
    step();
    $display("rst_mid after sv=%0d sd=%h", scan_data_valid, scan_data);
    check_all_zero("rst_mid_after");
    step();
    check("rst_mid later scan_data_valid", 32'(scan_data_valid), 32'd0);
    check("rst_mid later ram_enable_b", 32'(ram_enable_b), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
